// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the ID-stage hazard/stall logic.
// Register-index width, the $zero index and the stall FSM state type.
package hazard_stall_unit_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // True when a producer destination feeds a source the ID instruction actually reads.
  function automatic logic reg_match(
    input logic [REG_W-1:0] i_rd,
    input logic [REG_W-1:0] i_rs,
    input logic [REG_W-1:0] i_rt,
    input logic             i_uses_rs,
    input logic             i_uses_rt
  );
    return (i_rd != REG_ZERO) &&
           (((i_rd == i_rs) && i_uses_rs) || ((i_rd == i_rt) && i_uses_rt));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_match.sv
// Combinational hazard detector: matches EX/MEM producers against ID sources and
// priority-encodes the number of stall cycles needed (0 = no hazard).
module hazard_match
  import hazard_stall_unit_pkg::*;
#(
  parameter int LD_BR_STALLS = 2
) (
  input  logic [REG_W-1:0] i_rs_id,
  input  logic [REG_W-1:0] i_rt_id,
  input  logic             i_uses_rs_id,
  input  logic             i_uses_rt_id,
  input  logic             i_branch_id,
  input  logic [REG_W-1:0] i_rd_ex,
  input  logic             i_regwrite_ex,
  input  logic             i_memread_ex,
  input  logic [REG_W-1:0] i_rd_mem,
  input  logic             i_memread_mem,
  output logic [1:0]       o_need
);

  logic w_match_ex;
  logic w_match_mem;

  assign w_match_ex  = reg_match(i_rd_ex, i_rs_id, i_rt_id, i_uses_rs_id, i_uses_rt_id);
  assign w_match_mem = reg_match(i_rd_mem, i_rs_id, i_rt_id, i_uses_rs_id, i_uses_rt_id);

  always_comb begin
    o_need = 2'd0;
    if (i_branch_id && i_memread_ex && w_match_ex) begin
      o_need = 2'(LD_BR_STALLS);
    end else if (i_memread_ex && w_match_ex) begin
      o_need = 2'd1;
    end else if (i_branch_id && i_regwrite_ex && w_match_ex) begin
      o_need = 2'd1;
    end else if (i_branch_id && i_memread_mem && w_match_mem) begin
      o_need = 2'd1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall unit: holds PC and IF/ID, bubbles ID/EX for hazards forwarding cannot
// cover, flushes IF/ID on taken branches and counts stall cycles (saturating).
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int LD_BR_STALLS = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [REG_W-1:0] RS_ID,
  input  logic [REG_W-1:0] RT_ID,
  input  logic             UsesRS_ID,
  input  logic             UsesRT_ID,
  input  logic             Branch_ID,
  input  logic             BranchTaken_ID,
  input  logic [REG_W-1:0] RD_EX,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [REG_W-1:0] RD_MEM,
  input  logic             MemRead_MEM,
  input  logic             Freeze,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic [CNT_W-1:0] StallCycles
);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_rem;
  logic [1:0]       w_rem_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [1:0]       w_need;
  logic             w_stall;

  hazard_match #(
    .LD_BR_STALLS (LD_BR_STALLS)
  ) u_match (
    .i_rs_id       (RS_ID),
    .i_rt_id       (RT_ID),
    .i_uses_rs_id  (UsesRS_ID),
    .i_uses_rt_id  (UsesRT_ID),
    .i_branch_id   (Branch_ID),
    .i_rd_ex       (RD_EX),
    .i_regwrite_ex (RegWrite_EX),
    .i_memread_ex  (MemRead_EX),
    .i_rd_mem      (RD_MEM),
    .i_memread_mem (MemRead_MEM),
    .o_need        (w_need)
  );

  // Single-cycle needs stay in RUN so the condition is re-checked behind the bubble.
  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    w_stall      = 1'b0;
    case (r_state)
      RUN: begin
        if (w_need != 2'd0) begin
          w_stall = 1'b1;
          if (w_need != 2'd1) begin
            w_state_next = STALL;
            w_rem_next   = w_need - 2'd1;
          end
        end
      end
      STALL: begin
        w_stall    = 1'b1;
        w_rem_next = r_rem - 2'd1;
        if (r_rem <= 2'd1) begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
        w_rem_next   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= RUN;
      r_rem       <= 2'd0;
      r_stall_cnt <= '0;
    end else if (!Freeze) begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  // Reset dominates Freeze; Freeze suppresses every enable, bubble and flush.
  always_comb begin
    PCWrite     = 1'b0;
    IFIDWrite   = 1'b0;
    IDEX_Bubble = 1'b1;
    IFID_Flush  = 1'b0;
    if (Rst) begin
      IDEX_Bubble = 1'b0;
      if (!Freeze) begin
        PCWrite     = !w_stall;
        IFIDWrite   = !w_stall;
        IDEX_Bubble = w_stall;
        IFID_Flush  = BranchTaken_ID && !w_stall;
      end
    end
  end

  assign StallCycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench: a remaining-stall-cycles model checked every negedge, plus
// literal expectations on the directed pipeline scenarios.
module tb_hazard_stall_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  RS_ID, RT_ID, RD_EX, RD_MEM;
  logic        UsesRS_ID, UsesRT_ID, Branch_ID, BranchTaken_ID;
  logic        RegWrite_EX, MemRead_EX, MemRead_MEM, Freeze;
  logic        PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush;
  logic [15:0] StallCycles;
  logic        s_PCWrite, s_IFIDWrite, s_IDEX_Bubble, s_IFID_Flush;
  logic [1:0]  s_StallCycles;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  hazard_stall_unit #(.CNT_W(16), .LD_BR_STALLS(2)) u_dut (
    .Clk(Clk), .Rst(Rst), .RS_ID(RS_ID), .RT_ID(RT_ID), .UsesRS_ID(UsesRS_ID),
    .UsesRT_ID(UsesRT_ID), .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID),
    .RD_EX(RD_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .RD_MEM(RD_MEM), .MemRead_MEM(MemRead_MEM), .Freeze(Freeze),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEX_Bubble(IDEX_Bubble),
    .IFID_Flush(IFID_Flush), .StallCycles(StallCycles)
  );

  hazard_stall_unit #(.CNT_W(2), .LD_BR_STALLS(2)) u_sat (
    .Clk(Clk), .Rst(Rst), .RS_ID(RS_ID), .RT_ID(RT_ID), .UsesRS_ID(UsesRS_ID),
    .UsesRT_ID(UsesRT_ID), .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID),
    .RD_EX(RD_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .RD_MEM(RD_MEM), .MemRead_MEM(MemRead_MEM), .Freeze(Freeze),
    .PCWrite(s_PCWrite), .IFIDWrite(s_IFIDWrite), .IDEX_Bubble(s_IDEX_Bubble),
    .IFID_Flush(s_IFID_Flush), .StallCycles(s_StallCycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_left = 0;     // forced stall cycles still owed after this one
  int m_cnt  = 0;     // 16-bit counter
  int m_cnt2 = 0;     // 2-bit counter

  function automatic int need_f();
    bit hit_ex, hit_mem;
    hit_ex  = (RD_EX != 0) && ((RD_EX == RS_ID && UsesRS_ID) || (RD_EX == RT_ID && UsesRT_ID));
    hit_mem = (RD_MEM != 0) && ((RD_MEM == RS_ID && UsesRS_ID) || (RD_MEM == RT_ID && UsesRT_ID));
    if (Branch_ID && MemRead_EX && hit_ex) return 2;
    if (MemRead_EX && hit_ex) return 1;
    if (Branch_ID && RegWrite_EX && hit_ex) return 1;
    if (Branch_ID && MemRead_MEM && hit_mem) return 1;
    return 0;
  endfunction

  always @(negedge Clk) begin
    bit e_pc, e_bub, e_fl, stall;
    int n;
    if (!Rst) begin
      m_left = 0; m_cnt = 0; m_cnt2 = 0;
      e_pc = 0; e_bub = 1; e_fl = 0;
    end
    chk("m_cnt", 32'(StallCycles), 32'(m_cnt));
    chk("m_cnt2", 32'(s_StallCycles), 32'(m_cnt2));
    if (Rst) begin
      if (Freeze) begin
        e_pc = 0; e_bub = 0; e_fl = 0;
      end else begin
        if (m_left > 0) begin
          stall = 1; m_left--;
        end else begin
          n = need_f();
          stall = (n > 0);
          if (stall) m_left = n - 1;
        end
        e_pc = !stall; e_bub = stall; e_fl = BranchTaken_ID && !stall;
        if (stall) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
    end
    chk("m_pcwrite", 32'(PCWrite), 32'(e_pc));
    chk("m_ifidwrite", 32'(IFIDWrite), 32'(e_pc));
    chk("m_bubble", 32'(IDEX_Bubble), 32'(e_bub));
    chk("m_flush", 32'(IFID_Flush), 32'(e_fl));
    chk("m_sat_pcwrite", 32'(s_PCWrite), 32'(e_pc));
  end

  // ---------------- directed stimulus ----------------
  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic br, input logic bt,
                        input logic [4:0] rdex, input logic rwex, input logic mrex,
                        input logic [4:0] rdmem, input logic mrmem);
    RS_ID = rs; RT_ID = rt; UsesRS_ID = urs; UsesRT_ID = urt; Branch_ID = br;
    BranchTaken_ID = bt; RD_EX = rdex; RegWrite_EX = rwex; MemRead_EX = mrex;
    RD_MEM = rdmem; MemRead_MEM = mrmem;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic look();
    @(negedge Clk); #1;
  endtask

  task automatic lit(input string tag, input bit pc, input bit bub, input bit fl);
    chk({tag, "_pcwrite"}, 32'(PCWrite), 32'(pc));
    chk({tag, "_ifidwrite"}, 32'(IFIDWrite), 32'(pc));
    chk({tag, "_bubble"}, 32'(IDEX_Bubble), 32'(bub));
    chk({tag, "_flush"}, 32'(IFID_Flush), 32'(fl));
    $display("txn %s pc=%0b ifid=%0b bub=%0b flush=%0b cnt=%0d sat=%0d", tag,
             PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, StallCycles, s_StallCycles);
  endtask

  logic [15:0] c0;

  initial begin
    Rst = 1'b0; Freeze = 1'b0; idle();
    #2 lit("reset", 0, 1, 0);
    chk("reset_cnt", 32'(StallCycles), 32'd0);
    tick(); tick();
    Rst = 1'b1;
    look(); lit("idle", 1, 0, 0);

    // lw $2 in EX, add reads rs=2 -> one stall then run
    tick(); set_in(5'd2, 5'd7, 1, 1, 0, 0, 5'd2, 1, 1, 5'd0, 0);
    look(); lit("lduse", 0, 1, 0);
    tick(); set_in(5'd2, 5'd7, 1, 1, 0, 0, 5'd0, 0, 0, 5'd2, 1);
    look(); lit("lduse_after", 1, 0, 0);
    chk("lduse_cnt", 32'(StallCycles), 32'd1);

    // beq rs=3 with lw $3 in EX: two stalls, flush only on third cycle
    tick(); set_in(5'd3, 5'd9, 1, 1, 1, 1, 5'd3, 1, 1, 5'd0, 0);
    look(); lit("ldbr1", 0, 1, 0);
    tick(); set_in(5'd3, 5'd9, 1, 1, 1, 1, 5'd0, 0, 0, 5'd3, 1);
    look(); lit("ldbr2", 0, 1, 0);
    tick(); set_in(5'd3, 5'd9, 1, 1, 1, 1, 5'd0, 0, 0, 5'd0, 0);
    look(); lit("ldbr3", 1, 0, 1);
    chk("ldbr_cnt", 32'(StallCycles), 32'd3);

    // beq rt=4 with add $4 in EX: one stall, then taken flush
    tick(); set_in(5'd8, 5'd4, 1, 1, 1, 0, 5'd4, 1, 0, 5'd0, 0);
    look(); lit("alubr", 0, 1, 0);
    tick(); set_in(5'd8, 5'd4, 1, 1, 1, 1, 5'd0, 0, 0, 5'd4, 0);
    look(); lit("alubr_flush", 1, 0, 1);

    // $zero destination and unused source never stall
    tick(); set_in(5'd0, 5'd0, 1, 0, 0, 0, 5'd0, 1, 1, 5'd0, 0);
    look(); lit("zero", 1, 0, 0);
    tick(); set_in(5'd6, 5'd1, 0, 1, 0, 0, 5'd6, 1, 1, 5'd0, 0);
    look(); lit("unused", 1, 0, 0);

    // branch on a load now in MEM -> one stall
    tick(); set_in(5'd5, 5'd1, 1, 1, 1, 0, 5'd0, 0, 0, 5'd5, 1);
    look(); lit("membr", 0, 1, 0);
    tick(); idle();

    // Freeze for 3 cycles inside STALL
    tick(); set_in(5'd3, 5'd9, 1, 1, 1, 1, 5'd3, 1, 1, 5'd0, 0);
    look(); c0 = StallCycles;
    tick(); set_in(5'd3, 5'd9, 1, 1, 1, 1, 5'd0, 0, 0, 5'd3, 1); Freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look(); lit("freeze", 0, 0, 0);
      chk("freeze_cnt", 32'(StallCycles), 32'(c0) + 32'd1);
      tick();
    end
    Freeze = 1'b0;
    look(); lit("unfreeze", 0, 1, 0);
    tick(); set_in(5'd3, 5'd9, 1, 1, 1, 1, 5'd0, 0, 0, 5'd0, 0);
    look(); lit("resume", 1, 0, 1);
    chk("resume_cnt", 32'(StallCycles), 32'(c0) + 32'd2);

    // reset asserted in STALL aborts the rest
    tick(); set_in(5'd3, 5'd9, 1, 1, 1, 0, 5'd3, 1, 1, 5'd0, 0);
    tick(); set_in(5'd3, 5'd9, 1, 1, 1, 0, 5'd0, 0, 0, 5'd3, 1);
    Rst = 1'b0;
    #1 lit("rst_mid", 0, 1, 0);
    chk("rst_mid_cnt", 32'(StallCycles), 32'd0);
    tick(); Rst = 1'b1; idle();
    look(); lit("rst_after", 1, 0, 0);
    chk("rst_after_cnt", 32'(StallCycles), 32'd0);

    // five load-use stalls: 2-bit counter saturates at 3
    tick(); set_in(5'd2, 5'd0, 1, 0, 0, 0, 5'd2, 1, 1, 5'd0, 0);
    repeat (5) tick();
    idle();
    look(); lit("sat_after", 1, 0, 0);
    chk("sat_cnt16", 32'(StallCycles), 32'd5);
    chk("sat_cnt2", 32'(s_StallCycles), 32'd3);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
